v810_bus_initiator: RTL and testbench
=====================================

Name: v810_bus_initiator

Overview:
- Bus-master engine that generates V810 external bus cycles from a simple request/acknowledge port.
- It is the initiator side of the same bus that the ROM/RAM responders and the data bus resizer answer.
- Used by the DMA/bus-test path and by benches that drive memory models without the CPU core.
- Handles wait states (READYn), dynamic 16-bit sizing (SZRQn split into two cycles) and a no-response watchdog.

Parameters:
- TIMEOUT, 255: maximum wait T-states per bus cycle before abort; 0 disables the watchdog.

Ports:
- CLK      in   1   system clock
- RES      in   1   synchronous active-high reset; takes effect on any CLK edge, independent of CE
- CE       in   1   clock enable; one T-state per CE=1 edge
- REQ      in   1   request valid; sampled only in IDLE
- REQ_A    in   32  byte address; bits [1:0] ignored and driven 0 on A
- REQ_BEn  in   4   active-low byte enables
- REQ_RW   in   1   1 = read, 0 = write
- REQ_ST   in   2   bus status code, passed to ST
- REQ_WD   in   32  write data
- ACK      out  1   one-CE-cycle pulse when the transaction completes
- ACK_RD   out  32  read data, valid while ACK=1
- ERR      out  1   one-CE-cycle pulse on watchdog abort; ACK stays 0
- BUSY     out  1   1 from request accept until ACK or ERR
- A        out  32  bus address
- D_I      in   32  bus read data
- D_O      out  32  bus write data
- BEn      out  4   bus byte enables
- ST       out  2   bus status
- DAn      out  1   data access strobe, active low
- MRQn     out  1   memory request, active low
- RW       out  1   bus direction
- BCYSTn   out  1   bus-cycle start, active low, first T-state only
- READYn   in   1   responder ready, active low
- SZRQn    in   1   responder requests 16-bit sizing, active low

Behaviour:
- Reset values:
  - A=0, D_O=0, BEn=4'hF, ST=0, RW=1.
  - DAn=1, MRQn=1, BCYSTn=1.
  - ACK=0, ACK_RD=0, ERR=0, BUSY=0.
  - State=IDLE, wait counter=0.
- Reset mid-cycle: the transaction is dropped, no ACK or ERR is issued, and the bus returns to idle on the same edge.
- All other state changes happen only on CLK edges where CE=1. Outputs are registered.
- States: IDLE, T1, TW, T1H, TWH.
- IDLE:
  - If REQ=1: latch all REQ_* fields, set BUSY=1, go to T1.
  - In that same edge drive A={REQ_A[31:2],2'b00}, BEn, ST, RW, D_O (write data driven for writes only; held otherwise), MRQn=0, DAn=0, BCYSTn=0.
- T1:
  - BCYSTn returns to 1 on the next edge. MRQn, DAn and the address/control signals are held. Go to TW.
  - READYn is not sampled in T1, so the minimum cycle is 2 T-states.
- TW: sample READYn and SZRQn each CE edge.
  - READYn=1: increment the wait counter. If TIMEOUT≠0 and the counter reaches TIMEOUT, deassert the bus, pulse ERR, BUSY=0, go to IDLE.
  - READYn=0, and split is not needed: capture D_I for reads, deassert DAn/MRQn, pulse ACK with ACK_RD=D_I, BUSY=0, go to IDLE.
  - READYn=0, and split is needed: capture D_I[15:0] into ACK_RD[15:0], go to T1H.
  - Split is needed iff SZRQn=0 AND BEn[1:0]≠2'b11 AND BEn[3:2]≠2'b11.
- T1H/TWH (upper-half cycle):
  - A=latched A|2, BEn={BEn[3:2],2'b11}, BCYSTn=0 for one T-state, DAn/MRQn held 0 throughout. D_O is unchanged; the upper lanes carry the data.
  - TWH completes on READYn=0: ACK_RD[31:16]=D_I[31:16], pulse ACK. SZRQn is ignored in TWH.
  - The watchdog is restarted at T1H.
- Write transactions: ACK_RD=0.
- ACK and ERR are never both 1.
- Back-to-back: a new REQ is accepted in the CE edge right after ACK/ERR (IDLE lasts one T-state minimum), giving one idle T-state between cycles.
- A REQ seen while BUSY=1 is ignored; the requester holds REQ until it sees ACK/ERR.
- Wait counter width: ceil(log2(TIMEOUT+1)) bits, saturating.

Test Plan:
- Read 0xFFF00010, BEn=0, READYn=0 in the first TW → BCYSTn low 1 T-state; ACK in T-state 2 with ACK_RD=D_I=0x12345678; BUSY high 2 T-states.
- Write 0x00000004, WD=0xCAFEBABE, BEn=4'b1100, READYn held high 3 extra T-states → D_O=0xCAFEBABE stable throughout; ACK at T-state 5.
- Read 0xFFF00020, BEn=0, SZRQn=0 with READYn=0 → second cycle at A=0xFFF00022, BEn=4'b0011; lower D_I=0x0000BEEF then upper 0xDEAD0000; ACK_RD=0xDEADBEEF.
- SZRQn=0 with BEn=4'b1100 → no split, single cycle, ACK.
- TIMEOUT=4, READYn never low → ERR pulse after 4 wait T-states, no ACK, DAn/MRQn=1, BUSY=0.
- RES=1 during TW of a read → all outputs at reset values next edge, no ACK; new REQ after RES=0 completes normally.

Source files
------------

// File: rtl/v810_bus_initiator.sv
// V810 external bus master. Turns a request/acknowledge transaction into
// one bus cycle, or two when the responder asks for 16-bit sizing. Wait
// states come from READYn, and a watchdog aborts a cycle that gets no answer.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | bus released, waiting for REQ
// T1    | first T-state of a cycle, BCYSTn low, READYn not sampled
// TW    | wait/data T-state, samples READYn and SZRQn
// T1H   | first T-state of the upper-halfword cycle of a split access
// TWH   | wait/data T-state of the upper-halfword cycle
module v810_bus_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic        REQ,
  input  logic [31:0] REQ_A,
  input  logic [3:0]  REQ_BEn,
  input  logic        REQ_RW,
  input  logic [1:0]  REQ_ST,
  input  logic [31:0] REQ_WD,
  output logic        ACK,
  output logic [31:0] ACK_RD,
  output logic        ERR,
  output logic        BUSY,
  output logic [31:0] A,
  input  logic [31:0] D_I,
  output logic [31:0] D_O,
  output logic [3:0]  BEn,
  output logic [1:0]  ST,
  output logic        DAn,
  output logic        MRQn,
  output logic        RW,
  output logic        BCYSTn,
  input  logic        READYn,
  input  logic        SZRQn
);

  // A width of at least one bit keeps the counter legal when the watchdog is off.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_TW,
    S_T1H,
    S_TWH
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;
  logic          split_req;

  // The address is always word aligned on the bus, so the low bits are dropped.
  logic unused_req_a;
  assign unused_req_a = ^REQ_A[1:0];

  // Saturating wait count, watchdog compare and the sizing decision. BEn still
  // holds the original enables while in TW, so it doubles as the latched copy.
  always_comb begin
    cnt_inc     = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
    timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_C);
    split_req   = !SZRQn && (BEn[1:0] != 2'b11) && (BEn[3:2] != 2'b11);
  end

  // Bus-cycle sequencer; every bus output is a register of this block.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      A        <= '0;
      D_O      <= '0;
      BEn      <= 4'hF;
      ST       <= 2'b00;
      RW       <= 1'b1;
      DAn      <= 1'b1;
      MRQn     <= 1'b1;
      BCYSTn   <= 1'b1;
      ACK      <= 1'b0;
      ACK_RD   <= '0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
    end else if (CE) begin
      ACK <= 1'b0;
      ERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (REQ) begin
            A        <= {REQ_A[31:2], 2'b00};
            BEn      <= REQ_BEn;
            ST       <= REQ_ST;
            RW       <= REQ_RW;
            if (!REQ_RW) D_O <= REQ_WD;
            MRQn     <= 1'b0;
            DAn      <= 1'b0;
            BCYSTn   <= 1'b0;
            BUSY     <= 1'b1;
            wait_cnt <= '0;
            state    <= S_T1;
          end
        end
        S_T1, S_T1H: begin
          BCYSTn <= 1'b1;
          state  <= (state == S_T1) ? S_TW : S_TWH;
        end
        S_TW, S_TWH: begin
          if (READYn) begin
            wait_cnt <= cnt_inc;
            if (timeout_hit) begin
              DAn   <= 1'b1;
              MRQn  <= 1'b1;
              ERR   <= 1'b1;
              BUSY  <= 1'b0;
              state <= S_IDLE;
            end
          end else if (state == S_TW && split_req) begin
            // Lower halfword is done; rerun the cycle for the upper lanes.
            ACK_RD[15:0] <= D_I[15:0];
            A            <= {A[31:2], 2'b10};
            BEn          <= {BEn[3:2], 2'b11};
            BCYSTn       <= 1'b0;
            wait_cnt     <= '0;
            state        <= S_T1H;
          end else begin
            if (!RW)
              ACK_RD <= '0;
            else if (state == S_TWH)
              ACK_RD[31:16] <= D_I[31:16];
            else
              ACK_RD <= D_I;
            DAn   <= 1'b1;
            MRQn  <= 1'b1;
            ACK   <= 1'b1;
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v810_bus_initiator.sv
// Randomized scoreboard bench for v810_bus_initiator. The stimulus side
// computes each transaction's outcome from the bus rules and queues it.
// A responder model answers the bus cycles, and a monitor compares what
// the DUT presents against the queued expectations.
module tb_v810_bus_initiator;
  localparam int TO = 4;

  typedef struct { bit is_err; logic [31:0] rd; int ts; } resp_t;
  typedef struct { logic [31:0] a; logic [3:0] ben; logic [1:0] st; logic rw; logic [31:0] d_o; } bus_t;
  typedef struct { int w; bit sz; logic [31:0] d; } plan_t;

  logic        CLK = 1'b0;
  logic        RES, CE, REQ, REQ_RW, READYn, SZRQn;
  logic [31:0] REQ_A, REQ_WD, D_I;
  logic [3:0]  REQ_BEn;
  logic [1:0]  REQ_ST;
  logic        ACK, ERR, BUSY, DAn, MRQn, RW, BCYSTn;
  logic [31:0] ACK_RD, A, D_O;
  logic [3:0]  BEn;
  logic [1:0]  ST;

  v810_bus_initiator #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RES(RES), .CE(CE), .REQ(REQ), .REQ_A(REQ_A), .REQ_BEn(REQ_BEn),
    .REQ_RW(REQ_RW), .REQ_ST(REQ_ST), .REQ_WD(REQ_WD), .ACK(ACK), .ACK_RD(ACK_RD),
    .ERR(ERR), .BUSY(BUSY), .A(A), .D_I(D_I), .D_O(D_O), .BEn(BEn), .ST(ST),
    .DAn(DAn), .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .READYn(READYn), .SZRQn(SZRQn)
  );

  always #5 CLK = ~CLK;

  logic ce_seen = 1'b0;
  logic res_seen = 1'b0;
  always @(posedge CLK) begin
    ce_seen  <= CE;
    res_seen <= RES;
  end

  resp_t exp_q[$];
  bus_t  bus_q[$];
  plan_t plan_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    ce_force = 1'b0;
  logic  ce_val = 1'b0;
  logic [31:0] d_o_model = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Clock enable: mostly high, with random stalls.
  initial begin
    CE = 1'b0;
    forever begin
      @(negedge CLK);
      #1;
      CE = ce_force ? ce_val : ($urandom_range(3) != 0);
    end
  end

  // Responder: one plan per bus cycle, READYn held high for plan.w T-states.
  initial begin
    plan_t cur;
    int    rem;
    bit    act;
    act = 1'b0; rem = 0;
    READYn = 1'b1; SZRQn = 1'b1; D_I = '0;
    forever begin
      @(negedge CLK);
      if (res_seen) begin
        act = 1'b0;
        plan_q.delete();
        READYn = 1'b1;
      end else if (ce_seen) begin
        if (BCYSTn === 1'b0) begin
          if (plan_q.size() > 0) cur = plan_q.pop_front();
          else begin cur.w = 0; cur.sz = 1'b1; cur.d = $urandom; end
          rem = cur.w; act = 1'b1;
          READYn = 1'($urandom_range(1));
          SZRQn = 1'($urandom_range(1));
          D_I = $urandom;
        end else if (act && rem == 0) begin
          READYn = 1'b0; SZRQn = cur.sz; D_I = cur.d; act = 1'b0;
        end else begin
          if (act) rem--;
          READYn = 1'b1; SZRQn = 1'($urandom_range(1)); D_I = $urandom;
        end
      end
    end
  end

  // Monitor: checks every cycle start, held bus signals and every response.
  initial begin
    resp_t e;
    bus_t  b, cur;
    int    busy_len;
    bit    in_cyc;
    busy_len = 0; in_cyc = 1'b0;
    cur = '{a: '0, ben: '0, st: '0, rw: 1'b0, d_o: '0};
    forever begin
      @(negedge CLK);
      if (res_seen) begin
        busy_len = 0; in_cyc = 1'b0;
      end else if (ce_seen) begin
        if (BUSY === 1'b1) busy_len++;
        if (ACK === 1'b1 || ERR === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_resp: got ACK=%b ERR=%b expected no response", ACK, ERR);
          end else begin
            e = exp_q.pop_front();
            chk("resp_kind", 32'({ACK, ERR}), e.is_err ? 32'd1 : 32'd2);
            if (!e.is_err) chk("ack_rd", ACK_RD, e.rd);
            chk("busy_tstates", 32'(busy_len), 32'(e.ts));
            chk("released_bus", 32'({DAn, MRQn, BUSY}), 32'b110);
          end
          busy_len = 0; in_cyc = 1'b0;
        end
        if (BCYSTn === 1'b0) begin
          if (bus_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_cycle: got cycle at A=%h expected none", A);
          end else begin
            b = bus_q.pop_front();
            chk("cyc_a", A, b.a);
            chk("cyc_ben", 32'(BEn), 32'(b.ben));
            chk("cyc_st", 32'(ST), 32'(b.st));
            chk("cyc_rw", 32'(RW), 32'(b.rw));
            chk("cyc_do", D_O, b.d_o);
            chk("cyc_strobes", 32'({MRQn, DAn, BUSY}), 32'b001);
            cur = b; in_cyc = 1'b1;
          end
        end else if (in_cyc && MRQn === 1'b0) begin
          chk("hold_a", A, cur.a);
          chk("hold_ben", 32'(BEn), 32'(cur.ben));
          chk("hold_do", D_O, cur.d_o);
        end
      end
    end
  end

  task automatic finish_now();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_a"}, A, 32'h0);
    chk({tag, "_do"}, D_O, 32'h0);
    chk({tag, "_ben"}, 32'(BEn), 32'hF);
    chk({tag, "_st_rw"}, 32'({ST, RW}), 32'b001);
    chk({tag, "_strobes"}, 32'({DAn, MRQn, BCYSTn}), 32'b111);
    chk({tag, "_ack_err_busy"}, 32'({ACK, ERR, BUSY}), 32'b000);
    chk({tag, "_ack_rd"}, ACK_RD, 32'h0);
  endtask

  // One transaction: model the outcome, queue expectations, drive REQ until done.
  task automatic do_txn(input logic [31:0] a, input logic [3:0] ben, input logic rw,
                        input logic [1:0] st, input logic [31:0] wd,
                        input int w1, input bit sz1, input logic [31:0] d1,
                        input int w2, input bit sz2, input logic [31:0] d2);
    resp_t r;
    bit    split, done;
    int    k, seen;
    logic [31:0] a_al;
    a_al = {a[31:2], 2'b00};
    if (!rw) d_o_model = wd;
    bus_q.push_back('{a: a_al, ben: ben, st: st, rw: rw, d_o: d_o_model});
    plan_q.push_back('{w: w1, sz: sz1, d: d1});
    split = !sz1 && (ben[1:0] != 2'b11) && (ben[3:2] != 2'b11);
    r.rd = '0;
    if (w1 >= TO) begin
      r.is_err = 1'b1; r.ts = 1 + TO;
    end else if (!split) begin
      r.is_err = 1'b0; r.ts = 2 + w1;
      if (rw) r.rd = d1;
    end else begin
      bus_q.push_back('{a: a_al | 32'h2, ben: {ben[3:2], 2'b11}, st: st, rw: rw, d_o: d_o_model});
      plan_q.push_back('{w: w2, sz: sz2, d: d2});
      if (w2 >= TO) begin
        r.is_err = 1'b1; r.ts = 3 + w1 + TO;
      end else begin
        r.is_err = 1'b0; r.ts = 4 + w1 + w2;
        if (rw) r.rd = {d2[31:16], d1[15:0]};
      end
    end
    exp_q.push_back(r);
    REQ_A = a; REQ_BEn = ben; REQ_RW = rw; REQ_ST = st; REQ_WD = wd; REQ = 1'b1;
    done = 1'b0; k = 0; seen = 0;
    while (!done) begin
      @(negedge CLK);
      k++;
      if (k > 400) begin
        n_cmp++; n_bad++;
        $display("FAIL txn_timeout: got no ACK/ERR in 400 clocks, expected one");
        finish_now();
      end
      if (ce_seen) begin
        seen++;
        if (ACK === 1'b1 || ERR === 1'b1) done = 1'b1;
      end
      if (seen >= 1 && !done) begin
        // Once accepted, the request fields must no longer matter.
        REQ_A = $urandom; REQ_WD = $urandom; REQ_BEn = 4'($urandom);
        REQ_RW = 1'($urandom); REQ_ST = 2'($urandom);
      end
    end
    if ($urandom_range(2) == 0) begin
      REQ = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge CLK);
    end
  endtask

  // Reset arrives during TW of a read; the cycle vanishes without ACK or ERR.
  task automatic reset_mid_cycle();
    int k, seen;
    bus_q.push_back('{a: 32'h0000_0100, ben: 4'h0, st: 2'd2, rw: 1'b1, d_o: d_o_model});
    plan_q.push_back('{w: 3, sz: 1'b1, d: 32'h1111_2222});
    REQ_A = 32'h0000_0101; REQ_BEn = 4'h0; REQ_RW = 1'b1; REQ_ST = 2'd2; REQ = 1'b1;
    k = 0; seen = 0;
    while (seen < 2) begin
      @(negedge CLK);
      k++;
      if (k > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL reset_setup_timeout: got no T1/TW in 100 clocks, expected two T-states");
        finish_now();
      end
      if (ce_seen) seen++;
    end
    RES = 1'b1; REQ = 1'b0; ce_force = 1'b1; ce_val = 1'b0;
    @(negedge CLK);
    check_reset("midrst");
    d_o_model = '0;
    RES = 1'b0; ce_force = 1'b0;
    repeat (6) @(negedge CLK);
    chk("midrst_no_resp", 32'({ACK, ERR}), 32'b00);
  endtask

  initial begin
    RES = 1'b1; REQ = 1'b0; REQ_A = '0; REQ_BEn = 4'hF; REQ_RW = 1'b1; REQ_ST = '0; REQ_WD = '0;
    repeat (3) @(negedge CLK);
    check_reset("rst");
    RES = 1'b0;
    @(negedge CLK);

    do_txn(32'hFFF0_0010, 4'h0, 1'b1, 2'd0, 32'h0, 0, 1'b1, 32'h1234_5678, 0, 1'b1, 32'h0);
    do_txn(32'h0000_0004, 4'b1100, 1'b0, 2'd1, 32'hCAFE_BABE, 3, 1'b1, $urandom, 0, 1'b1, 32'h0);
    do_txn(32'hFFF0_0020, 4'h0, 1'b1, 2'd2, 32'h0, 0, 1'b0, 32'h0000_BEEF, 0, 1'b1, 32'hDEAD_0000);
    do_txn(32'h0000_1000, 4'b1100, 1'b1, 2'd0, 32'h0, 0, 1'b0, 32'h55AA_1234, 0, 1'b1, 32'h0);
    do_txn(32'h0000_2000, 4'h0, 1'b1, 2'd3, 32'h0, 10, 1'b1, 32'h0, 0, 1'b1, 32'h0);
    do_txn(32'h0000_3008, 4'h0, 1'b1, 2'd0, 32'h0, 1, 1'b0, 32'h0000_4444, 7, 1'b0, 32'h3333_0000);
    REQ = 1'b0;
    repeat (2) @(negedge CLK);
    reset_mid_cycle();
    do_txn(32'h0000_0200, 4'h0, 1'b1, 2'd0, 32'h0, 1, 1'b1, 32'hA5A5_0F0F, 0, 1'b1, 32'h0);

    for (int i = 0; i < 150; i++) begin
      do_txn($urandom, 4'($urandom), 1'($urandom), 2'($urandom), $urandom,
             int'($urandom_range(0, 5)), 1'($urandom), $urandom,
             int'($urandom_range(0, 5)), 1'($urandom), $urandom);
    end
    REQ = 1'b0;
    repeat (8) @(negedge CLK);
    chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("cycle_queue_drained", 32'(bus_q.size()), 32'd0);
    finish_now();
  end

endmodule
